// File: rtl/alu_cmd_scheduler.sv
// Two-requester command scheduler in front of a registered multi-unit ALU.
// Round-robin grant, one command in flight, result held until the consumer takes it.
module alu_cmd_scheduler #(
  parameter int In_out  = 16,
  parameter int ALU_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  input  logic [In_out-1:0] REQ0_A,
  input  logic [In_out-1:0] REQ0_B,
  input  logic [3:0]        REQ0_FUN,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [In_out-1:0] REQ1_A,
  input  logic [In_out-1:0] REQ1_B,
  input  logic [3:0]        REQ1_FUN,
  output logic              REQ1_READY,
  output logic [In_out-1:0] ALU_A,
  output logic [In_out-1:0] ALU_B,
  output logic [3:0]        ALU_FUN,
  output logic              Arith_Enable,
  output logic              Logic_Enable,
  output logic              CMP_Enable,
  output logic              Shift_Enable,
  input  logic [In_out-1:0] ALU_OUT,
  input  logic              ALU_Flag,
  output logic              RSP_VALID,
  output logic              RSP_ID,
  output logic [In_out-1:0] RSP_DATA,
  output logic              RSP_FLAG,
  input  logic              RSP_READY,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C = 3'(ALU_LAT);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [2:0]        cnt_r;
  logic              last_grant_r;
  logic              grant0_s;
  logic              grant1_s;
  logic              accept_s;
  logic [In_out-1:0] alu_a_r;
  logic [In_out-1:0] alu_b_r;
  logic [3:0]        alu_fun_r;
  logic [3:0]        unit_en_r;
  logic              rsp_valid_r;
  logic              rsp_id_r;
  logic              rsp_flag_r;
  logic [In_out-1:0] rsp_data_r;

  // One-hot unit select {Arith, Logic, CMP, Shift} from the function group bits
  function automatic logic [3:0] unit_sel(input logic [3:0] fun);
    logic [3:0] sel;
    case (fun[3:2])
      2'b00:   sel = 4'b1000;
      2'b01:   sel = 4'b0100;
      2'b10:   sel = 4'b0010;
      default: sel = 4'b0001;
    endcase
    return sel;
  endfunction

  // Round-robin grant; reset masks the grant so READY is low while RST is high
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == IDLE) && !RST) begin
      if (REQ0_VALID && (!REQ1_VALID || last_grant_r)) begin
        grant0_s = 1'b1;
      end else if (REQ1_VALID) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
      end
    end else begin
      grant1_s = 1'b0;
    end
  end

  assign accept_s = grant0_s | grant1_s;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? ISSUE : IDLE;
      ISSUE:   state_nxt_s = WAIT;
      WAIT:    state_nxt_s = (cnt_r == 3'd1) ? RESP : WAIT;
      RESP:    state_nxt_s = RSP_READY ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: handshake readies and busy indication
  always_comb begin
    REQ0_READY = grant0_s;
    REQ1_READY = grant1_s;
    if (state_r != IDLE) begin
      BUSY = 1'b1;
    end else begin
      BUSY = 1'b0;
    end
  end

  // Captured command; operands are cleared once the result has been sampled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_a_r   <= '0;
      alu_b_r   <= '0;
      alu_fun_r <= 4'd0;
      unit_en_r <= 4'd0;
      rsp_id_r  <= 1'b0;
    end else if (accept_s) begin
      alu_a_r   <= grant1_s ? REQ1_A   : REQ0_A;
      alu_b_r   <= grant1_s ? REQ1_B   : REQ0_B;
      alu_fun_r <= grant1_s ? REQ1_FUN : REQ0_FUN;
      unit_en_r <= unit_sel(grant1_s ? REQ1_FUN : REQ0_FUN);
      rsp_id_r  <= grant1_s;
    end else if (state_r == ISSUE) begin
      unit_en_r <= 4'd0;
    end else if ((state_r == WAIT) && (cnt_r == 3'd1)) begin
      alu_a_r   <= '0;
      alu_b_r   <= '0;
      alu_fun_r <= 4'd0;
    end else begin
      unit_en_r <= unit_en_r;
    end
  end

  // ALU latency down-counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= 3'd0;
    end else if (state_r == ISSUE) begin
      cnt_r <= LAT_C;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response capture and consumer handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_flag_r  <= 1'b0;
    end else if ((state_r == WAIT) && (cnt_r == 3'd1)) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= ALU_OUT;
      rsp_flag_r  <= ALU_Flag;
    end else if ((state_r == RESP) && RSP_READY) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Fairness pointer; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_r <= 1'b1;
    end else if ((state_r == RESP) && RSP_READY) begin
      last_grant_r <= rsp_id_r;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign ALU_A        = alu_a_r;
  assign ALU_B        = alu_b_r;
  assign ALU_FUN      = alu_fun_r;
  assign Arith_Enable = unit_en_r[3];
  assign Logic_Enable = unit_en_r[2];
  assign CMP_Enable   = unit_en_r[1];
  assign Shift_Enable = unit_en_r[0];
  assign RSP_VALID    = rsp_valid_r;
  assign RSP_ID       = rsp_id_r;
  assign RSP_DATA     = rsp_data_r;
  assign RSP_FLAG     = rsp_flag_r;

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Directed bench: instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=3, each behind a
// behavioral registered ALU that presents garbage except on the exact result cycle.
module tb_alu_cmd_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  r0_valid = 2'b00;
  logic [1:0]  r1_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] req0_a = 16'd0, req0_b = 16'd0, req1_a = 16'd0, req1_b = 16'd0;
  logic [3:0]  req0_fun = 4'd0, req1_fun = 4'd0;

  logic [1:0]  r0_ready, r1_ready, ae, le, ce, se, rsp_valid, rsp_id, rsp_flag, busy, alu_flag;
  logic [15:0] alu_a [2];
  logic [15:0] alu_b [2];
  logic [15:0] alu_out [2];
  logic [15:0] rsp_data [2];
  logic [3:0]  alu_fun [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] fun);
    logic [15:0] r;
    r = 16'd0;
    case (fun[3:2])
      2'b00: r = fun[0] ? a - b : a + b;
      2'b01: case (fun[1:0])
               2'd0: r = a & b;
               2'd1: r = a | b;
               2'd2: r = a ^ b;
               default: r = ~(a & b);
             endcase
      2'b10: case (fun[1:0])
               2'd0: r = {15'd0, a == b};
               2'd1: r = {15'd0, a > b};
               2'd2: r = {15'd0, a < b};
               default: r = 16'd0;
             endcase
      default: case (fun[1:0])
               2'd0: r = a >> 1;
               2'd1: r = a << 1;
               2'd2: r = b >> 1;
               default: r = b << 1;
             endcase
    endcase
    return {r == 16'd0, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [16:0] pipe [LAT];

    always @(posedge CLK) begin
      pipe[0] <= (ae[g] | le[g] | ce[g] | se[g]) ? alu_model(alu_a[g], alu_b[g], alu_fun[g])
                                                 : 17'h1DEAD;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign alu_out[g]  = pipe[LAT-1][15:0];
    assign alu_flag[g] = pipe[LAT-1][16];

    alu_cmd_scheduler #(.In_out(16), .ALU_LAT(LAT)) u_dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(r0_valid[g]), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_FUN(req0_fun),
      .REQ0_READY(r0_ready[g]),
      .REQ1_VALID(r1_valid[g]), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_FUN(req1_fun),
      .REQ1_READY(r1_ready[g]),
      .ALU_A(alu_a[g]), .ALU_B(alu_b[g]), .ALU_FUN(alu_fun[g]),
      .Arith_Enable(ae[g]), .Logic_Enable(le[g]), .CMP_Enable(ce[g]), .Shift_Enable(se[g]),
      .ALU_OUT(alu_out[g]), .ALU_Flag(alu_flag[g]),
      .RSP_VALID(rsp_valid[g]), .RSP_ID(rsp_id[g]), .RSP_DATA(rsp_data[g]),
      .RSP_FLAG(rsp_flag[g]), .RSP_READY(rsp_ready[g]), .BUSY(busy[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_or(input int d);
    return 32'(r0_ready[d] | r1_ready[d] | ae[d] | le[d] | ce[d] | se[d] | rsp_valid[d] |
               rsp_id[d] | rsp_flag[d] | busy[d] | (|alu_a[d]) | (|alu_b[d]) |
               (|alu_fun[d]) | (|rsp_data[d]));
  endfunction

  task automatic run_op(input int d, input logic who, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] fun, input logic [3:0] en, input logic [15:0] ed,
                        input logic ef, input int hold);
    int lat;
    int n;
    lat = (d == 0) ? 1 : 3;
    n = 0;
    @(negedge CLK);
    if (who) begin
      req1_a = a; req1_b = b; req1_fun = fun; r1_valid[d] = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_fun = fun; r0_valid[d] = 1'b1;
    end
    rsp_ready[d] = (hold == 0);
    #1;
    while (!(who ? r1_ready[d] : r0_ready[d]) && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    chk("accept", 32'(who ? r1_ready[d] : r0_ready[d]), 32'd1);
    chk("ready_excl", 32'(who ? r0_ready[d] : r1_ready[d]), 32'd0);
    @(negedge CLK);
    r0_valid[d] = 1'b1;
    r1_valid[d] = 1'b1;
    #1;
    chk("issue_en", 32'({ae[d], le[d], ce[d], se[d]}), 32'(en));
    chk("issue_fun", 32'(alu_fun[d]), 32'(fun));
    chk("issue_ab", {alu_a[d], alu_b[d]}, {a, b});
    chk("issue_busy", 32'(busy[d]), 32'd1);
    chk("issue_ready", 32'({r0_ready[d], r1_ready[d]}), 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge CLK); #1;
      chk("wait_en", 32'({ae[d], le[d], ce[d], se[d]}), 32'd0);
      chk("wait_fun", 32'(alu_fun[d]), 32'(fun));
      chk("wait_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("wait_ready", 32'({r0_ready[d], r1_ready[d]}), 32'd0);
    end
    @(negedge CLK); #1;
    chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    chk("rsp_id", 32'(rsp_id[d]), 32'(who));
    chk("rsp_data", 32'(rsp_data[d]), 32'(ed));
    chk("rsp_flag", 32'(rsp_flag[d]), 32'(ef));
    chk("rsp_ready_low", 32'({r0_ready[d], r1_ready[d]}), 32'd0);
    if (hold == 0) begin
      r0_valid[d] = 1'b0;
      r1_valid[d] = 1'b0;
    end
    for (int h = 1; h < hold; h++) begin
      @(negedge CLK); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_data", {15'd0, rsp_flag[d], rsp_data[d]}, {15'd0, ef, ed});
      chk("hold_busy", 32'(busy[d]), 32'd1);
      chk("hold_ready", 32'({r0_ready[d], r1_ready[d]}), 32'd0);
    end
    r0_valid[d] = 1'b0;
    r1_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge CLK); #1;
    chk("done_valid", 32'(rsp_valid[d]), 32'd0);
    chk("done_busy", 32'(busy[d]), 32'd0);
    rsp_ready[d] = 1'b0;
  endtask

  typedef struct {
    logic        who;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic [3:0]  en;
    logic [15:0] d;
    logic        f;
    int          hold;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 16'h1234, 16'h0101, 4'h0, 4'b1000, 16'h1335, 1'b0, 0};
    tbl[1]  = '{1'b1, 16'h1234, 16'h0234, 4'h1, 4'b1000, 16'h1000, 1'b0, 0};
    tbl[2]  = '{1'b0, 16'hFFFF, 16'h0001, 4'h2, 4'b1000, 16'h0000, 1'b1, 0};
    tbl[3]  = '{1'b1, 16'h0005, 16'h0005, 4'h3, 4'b1000, 16'h0000, 1'b1, 0};
    tbl[4]  = '{1'b1, 16'hF0F0, 16'h0FF0, 4'h4, 4'b0100, 16'h00F0, 1'b0, 0};
    tbl[5]  = '{1'b0, 16'h00F0, 16'h0FF0, 4'h5, 4'b0100, 16'h0FF0, 1'b0, 0};
    tbl[6]  = '{1'b1, 16'hAAAA, 16'hAAAA, 4'h6, 4'b0100, 16'h0000, 1'b1, 0};
    tbl[7]  = '{1'b0, 16'hFF00, 16'h0F0F, 4'h7, 4'b0100, 16'hF0FF, 1'b0, 0};
    tbl[8]  = '{1'b1, 16'h1234, 16'h1234, 4'h8, 4'b0010, 16'h0001, 1'b0, 0};
    tbl[9]  = '{1'b0, 16'h0001, 16'h0002, 4'h9, 4'b0010, 16'h0000, 1'b1, 0};
    tbl[10] = '{1'b1, 16'h0001, 16'h0002, 4'hA, 4'b0010, 16'h0001, 1'b0, 0};
    tbl[11] = '{1'b0, 16'h5555, 16'h1111, 4'hB, 4'b0010, 16'h0000, 1'b1, 0};
    tbl[12] = '{1'b1, 16'h8001, 16'h0000, 4'hC, 4'b0001, 16'h4000, 1'b0, 0};
    tbl[13] = '{1'b0, 16'h8001, 16'h0000, 4'hD, 4'b0001, 16'h0002, 1'b0, 0};
    tbl[14] = '{1'b1, 16'hFFFF, 16'h0001, 4'hE, 4'b0001, 16'h0000, 1'b1, 0};
    tbl[15] = '{1'b0, 16'h0000, 16'h4000, 4'hF, 4'b0001, 16'h8000, 1'b0, 0};
    tbl[16] = '{1'b1, 16'h1234, 16'h0101, 4'h0, 4'b1000, 16'h1335, 1'b0, 5};

    // Reset: outputs zero even with requests pending
    r0_valid[0] = 1'b1; r1_valid[0] = 1'b1; r0_valid[1] = 1'b1; rsp_ready[0] = 1'b1;
    #12;
    chk("reset_zero_d0", out_or(0), 32'd0);
    chk("reset_zero_d1", out_or(1), 32'd0);
    r0_valid[1] = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Round-robin with both requesters continuously valid
    for (int k = 0; k < 4; k++) begin
      #1; n = 0;
      while (!(r0_ready[0] | r1_ready[0]) && n < 20) begin
        @(negedge CLK); #1; n++;
      end
      chk("rr_grant1", 32'(r1_ready[0]), 32'(k % 2));
      chk("rr_grant0", 32'(r0_ready[0]), 32'((k + 1) % 2));
      @(negedge CLK); #1; n = 0;
      while (busy[0] && n < 20) begin
        if (rsp_valid[0]) chk("rr_rsp_id", 32'(rsp_id[0]), 32'(k % 2));
        @(negedge CLK); #1; n++;
      end
      chk("rr_done", 32'(busy[0]), 32'd0);
      if (k == 3) begin
        r0_valid[0] = 1'b0; r1_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
      end
    end

    // Function sweep plus a stalled-consumer case on the single-cycle-latency instance
    for (int i = 0; i < 17; i++)
      run_op(0, tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].fun, tbl[i].en, tbl[i].d, tbl[i].f,
             tbl[i].hold);

    // Three-cycle latency shift command
    run_op(1, 1'b0, 16'h8001, 16'h0000, 4'hC, 4'b0001, 16'h4000, 1'b0, 0);

    // Reset pulse in the middle of WAIT abandons the command
    @(negedge CLK);
    req0_a = 16'h1234; req0_b = 16'h0101; req0_fun = 4'h0;
    r0_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    #1;
    chk("rst_seq_accept", 32'(r0_ready[1]), 32'd1);
    @(negedge CLK);
    r0_valid[1] = 1'b0;
    @(negedge CLK);
    #2;
    chk("rst_seq_busy", 32'(busy[1]), 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_async_d1", out_or(1), 32'd0);
    chk("rst_async_d0", out_or(0), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); #1;
      chk("no_rsp_after_rst", 32'({rsp_valid[1], busy[1]}), 32'd0);
    end
    rsp_ready[1] = 1'b0;
    run_op(1, 1'b1, 16'h00F0, 16'h0FF0, 4'h6, 4'b0100, 16'h0F00, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_scheduler.md
ALU_CMD_SCHEDULER -- requirements
Module: alu_cmd_scheduler

Interface
REQ-001 SHALL have parameter In_out, default 16: operand/result width.
REQ-002 SHALL have parameter ALU_LAT, default 1, legal 1..4: cycles from enable edge to sampled ALU result.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REQ0_VALID / REQ1_VALID  input  1 each  requester n has a command.
REQ-006 SHALL have port REQ0_A, REQ0_B / REQ1_A, REQ1_B  input  In_out each  operands.
REQ-007 SHALL have port REQ0_FUN / REQ1_FUN  input  4 each  ALU function code.
REQ-008 SHALL have port REQ0_READY / REQ1_READY  output  1 each  command accepted this cycle.
REQ-009 SHALL have port ALU_A, ALU_B  output  In_out each  operands to ALU.
REQ-010 SHALL have port ALU_FUN  output  4  function code to ALU.
REQ-011 SHALL have port Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  output  1 each  unit enables.
REQ-012 SHALL have port ALU_OUT  input  In_out  registered ALU result.
REQ-013 SHALL have port ALU_Flag  input  1  OR of unit flags.
REQ-014 SHALL have port RSP_VALID  output  1  response available.
REQ-015 SHALL have port RSP_ID  output  1  requester index of response.
REQ-016 SHALL have port RSP_DATA  output  In_out  captured result.
REQ-017 SHALL have port RSP_FLAG  output  1  captured flag.
REQ-018 SHALL have port RSP_READY  input  1  consumer takes response.
REQ-019 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; no other transitions except reset.
REQ-021 IDLE: REQn_READY SHALL be combinationally high only for the granted requester; both low in all other states.
REQ-022 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not in last_grant wins.
REQ-023 On VALID&&READY edge SHALL capture A, B, FUN, ID into internal registers and go ISSUE.
REQ-024 ISSUE: exactly one cycle; exactly one enable high, decoded from FUN[3:2]: 00 Arith, 01 Logic, 10 CMP, 11 Shift.
REQ-025 ALU_A/ALU_B/ALU_FUN SHALL drive captured values from ISSUE through end of WAIT; enables SHALL be low outside ISSUE.
REQ-026 WAIT SHALL last exactly ALU_LAT cycles (down-counter loaded ALU_LAT on ISSUE exit); at end of last WAIT cycle SHALL sample ALU_OUT->RSP_DATA, ALU_Flag->RSP_FLAG.
REQ-027 RSP_VALID SHALL rise ALU_LAT+2 cycles after the accept edge; RSP_DATA/FLAG/ID stable while RSP_VALID high.
REQ-028 RESP: hold until RSP_VALID&&RSP_READY; on that edge go IDLE, RSP_VALID low, last_grant <= RSP_ID.
REQ-029 RSP_READY high on RESP entry SHALL complete in one cycle; new accept possible next cycle (IDLE).
REQ-030 REQn_VALID changes outside IDLE SHALL have no effect; withdrawn VALID in IDLE SHALL not be granted.
REQ-031 All 16 ALU_FUN codes SHALL be forwarded unchanged; no code rejected.

Reset
REQ-032 RST high SHALL immediately force IDLE, all outputs 0, last_grant=1 (REQ0 wins first tie), counter 0.
REQ-033 RST mid-operation SHALL abandon the command; no response is produced for it.
REQ-034 After RST falls, first acceptance SHALL occur no earlier than first rising CLK edge.

Verification
REQ-035 REQ0: A=0x00F0, B=0x0FF0, FUN=0101 (OR), RSP_READY=1 -> Logic_Enable one cycle, RSP_VALID at accept+3, RSP_ID=0, RSP_DATA=0x0FF0.
REQ-036 Both valid continuously after reset, 4 ops -> grant order 0,1,0,1.
REQ-037 RSP_READY low 5 cycles in RESP -> RSP_VALID/DATA stable 5 cycles, both REQn_READY low, BUSY=1.
REQ-038 ALU_LAT=3, FUN=1100 -> Shift_Enable one cycle, WAIT 3 cycles, RSP_VALID at accept+5.
REQ-039 RST pulse during WAIT -> all outputs 0 asynchronously, no RSP_VALID, next REQ1-only command accepted normally.
REQ-040 FUN sweep 0000..1111 -> enable per REQ-024, ALU_FUN equals request code each time.
